// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Optional build macro HAZ_STATS_EN adds saturating stall/forward event counters.
module hazard_forward_ctrl #(
    parameter int AW       = 4,
    parameter int NSRC     = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 ex_wen,
    input  logic [AW-1:0]        ex_waddr,
    input  logic                 ex_is_load,
    input  logic                 mem_wen,
    input  logic [AW-1:0]        mem_waddr,
    input  logic                 flush,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [NSRC*2-1:0]    fwd_sel_ex,
    output logic                 busy
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          fwd_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);
    localparam bit         MULTI    = (LOAD_LAT > 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    logic [NSRC-1:0]   m_ex;
    logic [NSRC-1:0]   m_mem;
    logic [NSRC*2-1:0] sel_calc;
    logic              hz;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [NSRC*2-1:0] fwd_sel_ex_q, fwd_sel_ex_d;
    logic              stall_c;
    logic              bubble_c;

    // Per-operand producer matching; the youngest producer (EX) has priority.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_op
            logic [AW-1:0] src;
            logic          src_zero;
            logic          rd_ok;

            assign src      = id_src_addr[gi*AW +: AW];
            assign src_zero = (ZERO_REG != 0) && (src == '0);
            assign rd_ok    = id_valid && id_src_used[gi] && !src_zero;

            assign m_ex[gi]  = rd_ok && ex_wen  && (ex_waddr  == src);
            assign m_mem[gi] = rd_ok && mem_wen && (mem_waddr == src);

            assign sel_calc[gi*2 +: 2] = (m_ex[gi] && !ex_is_load) ? SEL_EX  :
                                         m_mem[gi]                 ? SEL_MEM :
                                                                     SEL_RF;
        end
    endgenerate

    assign hz = |(m_ex & {NSRC{ex_is_load}});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fwd_sel_ex_d = '0;
        stall_c      = 1'b0;
        bubble_c     = 1'b0;

        if (flush) begin
            // Squashed consumer: drop any pending stall and send a NOP down.
            state_d  = ST_IDLE;
            cnt_d    = '0;
            bubble_c = 1'b1;
        end else if (state_q == ST_STALL) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            cnt_d    = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (hz) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = MULTI ? ST_STALL : ST_IDLE;
        end else begin
            fwd_sel_ex_d = sel_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fwd_sel_ex_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fwd_sel_ex_q <= fwd_sel_ex_d;
        end
    end

    // Held low while reset is asserted so no stall leaks out of a reset.
    assign stall_id   = stall_c  && !rst;
    assign bubble_ex  = bubble_c && !rst;
    assign fwd_sel_ex = fwd_sel_ex_q;
    assign busy       = (state_q == ST_STALL);

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((fwd_sel_ex_q != '0) && (fwd_cnt_q != 16'hFFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
